// File: rtl/sdram_sched.sv
// SDRAM command scheduler: arbitrates write/read requests and periodic auto-refresh
// onto one start/done command engine; stays silent until the engine reports init_done.
module sdram_sched #(
  parameter int REF_PERIOD = 780,
  parameter int URGENT_TH  = 4,
  parameter int CNT_W      = 10
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_init_done,
  input  logic       i_wr_req,
  input  logic       i_rd_req,
  output logic       o_wr_ack,
  output logic       o_rd_ack,
  output logic       o_cmd_start,
  output logic [1:0] o_cmd_type,
  input  logic       i_cmd_done,
  output logic [2:0] o_ref_pending,
  output logic       o_ref_overflow
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_REF  = 2'd1;
  localparam logic [1:0] CMD_WR   = 2'd2;
  localparam logic [1:0] CMD_RD   = 2'd3;

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(REF_PERIOD - 1);
  localparam logic [2:0]       URGENT     = 3'(URGENT_TH);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [2:0]       r_pending;
  logic             r_overflow;
  logic [1:0]       r_cmd_type;
  logic             r_cmd_start;
  logic             r_wr_ack;
  logic             r_rd_ack;
  logic             r_last_rw;

  logic             w_tick;
  logic             w_ref_done;
  logic [1:0]       w_choice;

  assign w_tick     = i_init_done && (r_timer == TIMER_LAST);
  assign w_ref_done = (r_state == S_BUSY) && i_cmd_done && (r_cmd_type == CMD_REF);

  // r_last_rw = 1 means the write side was served last
  always_comb begin
    w_choice = CMD_NONE;
    if (r_pending >= URGENT)
      w_choice = CMD_REF;
    else if (i_wr_req && i_rd_req)
      w_choice = r_last_rw ? CMD_RD : CMD_WR;
    else if (i_wr_req)
      w_choice = CMD_WR;
    else if (i_rd_req)
      w_choice = CMD_RD;
    else if (r_pending != 3'd0)
      w_choice = CMD_REF;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_timer <= '0;
    else if (!i_init_done || w_tick)
      r_timer <= '0;
    else
      r_timer <= r_timer + 1'b1;
  end

  // A tick and a finished refresh in the same cycle cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending  <= 3'd0;
      r_overflow <= 1'b0;
    end else if (!i_init_done) begin
      r_pending <= 3'd0;
    end else if (w_tick && !w_ref_done) begin
      if (r_pending == 3'd7)
        r_overflow <= 1'b1;
      else
        r_pending <= r_pending + 3'd1;
    end else if (w_ref_done && !w_tick && (r_pending != 3'd0)) begin
      r_pending <= r_pending - 3'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_cmd_type  <= CMD_NONE;
      r_cmd_start <= 1'b0;
      r_wr_ack    <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_last_rw   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_init_done && (w_choice != CMD_NONE)) begin
            r_state     <= S_BUSY;
            r_cmd_type  <= w_choice;
            r_cmd_start <= 1'b1;
          end
        end
        S_BUSY: begin
          r_cmd_start <= 1'b0;
          if (i_cmd_done) begin
            r_state    <= S_ACK;
            r_cmd_type <= CMD_NONE;
            r_wr_ack   <= (r_cmd_type == CMD_WR);
            r_rd_ack   <= (r_cmd_type == CMD_RD);
            if (r_cmd_type == CMD_WR)
              r_last_rw <= 1'b1;
            else if (r_cmd_type == CMD_RD)
              r_last_rw <= 1'b0;
          end
        end
        S_ACK: begin
          r_wr_ack <= 1'b0;
          r_rd_ack <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_wr_ack       = r_wr_ack;
  assign o_rd_ack       = r_rd_ack;
  assign o_cmd_start    = r_cmd_start;
  assign o_cmd_type     = r_cmd_type;
  assign o_ref_pending  = r_pending;
  assign o_ref_overflow = r_overflow;

endmodule

// File: tb/tb_sdram_sched.sv
// Bench for sdram_sched: directed scenarios plus random traffic, every cycle compared
// against a cycle-level reference model of the scheduling rules.
module tb_sdram_sched;
  localparam int P = 16;

  logic       clk = 1'b0;
  logic       rst, init_done, wr_req, rd_req, cmd_done;
  logic       wr_ack, rd_ack, cmd_start, ref_overflow;
  logic [1:0] cmd_type;
  logic [2:0] ref_pending;

  always #5 clk = ~clk;

  sdram_sched #(.REF_PERIOD(P), .URGENT_TH(4), .CNT_W(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_init_done(init_done),
    .i_wr_req(wr_req), .i_rd_req(rd_req),
    .o_wr_ack(wr_ack), .o_rd_ack(rd_ack),
    .o_cmd_start(cmd_start), .o_cmd_type(cmd_type),
    .i_cmd_done(cmd_done),
    .o_ref_pending(ref_pending), .o_ref_overflow(ref_overflow)
  );

  int n_pass = 0;
  int n_total = 0;

  // Reference model: phase 0 idle, 1 busy, 2 acknowledging; type 0 none,1 REF,2 WR,3 RD.
  int m_timer, m_pend, m_phase, m_type, m_busy;
  bit m_ovf, m_last_wr, m_start, m_wack, m_rack;

  // Stimulus controls: requesters and engine behaviour.
  bit init_r, wr_want, rd_want, wr_persist, rd_persist, sync_ref;
  int lat;
  bit ev_seen;
  int ev_pend_before;
  bit seen_start, seen_wr_start;

  function automatic void model_reset();
    m_timer = 0; m_pend = 0; m_phase = 0; m_type = 0; m_busy = 0;
    m_ovf = 0; m_last_wr = 0; m_start = 0; m_wack = 0; m_rack = 0;
  endfunction

  function automatic void model_edge(bit init, bit wr, bit rd, bit done);
    bit tick;
    bit ref_done;
    int choice;
    int nxt;
    tick     = init && (m_timer == P - 1);
    ref_done = (m_phase == 1) && done && (m_type == 1);
    choice = 0;
    if (m_pend >= 4) choice = 1;
    else if (wr && rd) choice = m_last_wr ? 3 : 2;
    else if (wr) choice = 2;
    else if (rd) choice = 3;
    else if (m_pend > 0) choice = 1;
    m_timer = (!init || tick) ? 0 : m_timer + 1;
    if (!init) m_pend = 0;
    else begin
      nxt = m_pend + int'(tick) - int'(ref_done);
      if (nxt > 7) begin nxt = 7; m_ovf = 1; end
      if (nxt < 0) nxt = 0;
      m_pend = nxt;
    end
    case (m_phase)
      0: begin
        m_start = 0; m_wack = 0; m_rack = 0;
        if (init && choice != 0) begin
          m_phase = 1; m_type = choice; m_start = 1; m_busy = 0;
        end
      end
      1: begin
        m_start = 0;
        m_busy++;
        if (done) begin
          m_phase = 2;
          m_wack = (m_type == 2);
          m_rack = (m_type == 3);
          if (m_type == 2) m_last_wr = 1;
          else if (m_type == 3) m_last_wr = 0;
          m_type = 0;
        end
      end
      default: begin
        m_wack = 0; m_rack = 0; m_phase = 0;
      end
    endcase
  endfunction

  function automatic logic [8:0] outvec();
    return {cmd_start, cmd_type, wr_ack, rd_ack, ref_pending, ref_overflow};
  endfunction

  function automatic logic [8:0] modelvec();
    return {m_start, 2'(m_type), m_wack, m_rack, 3'(m_pend), m_ovf};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic drive();
    if (m_wack && !wr_persist) wr_want = 0;
    if (m_rack && !rd_persist) rd_want = 0;
    init_done = init_r;
    wr_req    = wr_want && !m_wack;
    rd_req    = rd_want && !m_rack;
    cmd_done  = (m_phase == 1) &&
                ((lat >= 0 && m_busy == lat) ||
                 (sync_ref && m_type == 1 && init_r && m_timer == P - 1));
  endtask

  task automatic step();
    @(negedge clk);
    drive();
    @(posedge clk);
    if (init_done && cmd_done && m_phase == 1 && m_type == 1 && m_timer == P - 1) begin
      ev_seen = 1;
      ev_pend_before = m_pend;
    end
    model_edge(init_done, wr_req, rd_req, cmd_done);
    #1;
    if (cmd_start === 1'b1) seen_start = 1;
    if (cmd_start === 1'b1 && cmd_type === 2'd2) seen_wr_start = 1;
    chk("cycle", 32'(outvec()), 32'(modelvec()));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_start(input string tag, input int limit);
    bit ok;
    ok = 0;
    for (int i = 0; i < limit && !ok; i++) begin
      step();
      if (cmd_start === 1'b1) ok = 1;
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; init_done = 0; wr_req = 0; rd_req = 0; cmd_done = 0;
    init_r = 0; wr_want = 0; rd_want = 0; wr_persist = 0; rd_persist = 0;
    sync_ref = 0; lat = 3;
    model_reset();
    #1;
    chk("reset_outs", 32'(outvec()), 32'd0);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    rst = 1; init_done = 0; wr_req = 0; rd_req = 0; cmd_done = 0;
    do_reset();

    // 1: silent without init_done, then immediate grant
    wr_want = 1; lat = 5; seen_start = 0;
    run(2000);
    chk("t1_no_start", 32'(seen_start), 32'd0);
    chk("t1_pend", 32'(ref_pending), 32'd0);
    init_r = 1;
    step();
    chk("t1_start", 32'(cmd_start), 32'd1);
    chk("t1_type", 32'(cmd_type), 32'd2);

    // 2: single write, engine done 5 cycles after start
    do_reset();
    init_r = 1; wr_want = 1; lat = 5;
    step();
    chk("t2_start_lat", 32'(cmd_start), 32'd1);
    chk("t2_type", 32'(cmd_type), 32'd2);
    run(5);
    chk("t2_no_early_ack", 32'(wr_ack), 32'd0);
    step();
    chk("t2_ack", 32'(wr_ack), 32'd1);
    seen_wr_start = 0;
    run(40);
    chk("t2_no_regrant", 32'(seen_wr_start), 32'd0);

    // 3: both requesters held, round robin starting with write
    do_reset();
    init_r = 1; wr_want = 1; rd_want = 1; wr_persist = 1; rd_persist = 1; lat = 3;
    for (int k = 0; k < 4; k++) begin
      wait_start($sformatf("t3_start%0d", k), 50);
      chk($sformatf("t3_grant%0d", k), 32'(cmd_type), (k % 2 == 0) ? 32'd2 : 32'd3);
    end

    // 4: long operations let refresh debt become urgent
    do_reset();
    init_r = 1; wr_want = 1; rd_want = 1; wr_persist = 1; rd_persist = 1; lat = 40;
    begin
      bit got_ref;
      got_ref = 0;
      for (int i = 0; i < 600 && !got_ref; i++) begin
        step();
        if (cmd_start === 1'b1 && cmd_type === 2'd1) got_ref = 1;
      end
      chk("t4_ref_granted", 32'(got_ref), 32'd1);
      chk("t4_urgent", 32'(ref_pending >= 3'd4), 32'd1);
    end
    run(200);

    // 5: engine stalls forever; refresh count saturates and overflow sticks
    do_reset();
    init_r = 1; wr_want = 1; lat = -1;
    run(150);
    chk("t5_pend_sat", 32'(ref_pending), 32'd7);
    chk("t5_ovf", 32'(ref_overflow), 32'd1);
    init_r = 0;
    run(5);
    chk("t5_ovf_hold", 32'(ref_overflow), 32'd1);
    chk("t5_pend_clr", 32'(ref_pending), 32'd0);
    do_reset();
    chk("t5_ovf_rst", 32'(ref_overflow), 32'd0);

    // 6: tick coincides with refresh completion; then reset mid-operation
    do_reset();
    init_r = 1; wr_want = 1; lat = 50; sync_ref = 1; ev_seen = 0;
    for (int i = 0; i < 200 && !ev_seen; i++) step();
    chk("t6_event", 32'(ev_seen), 32'd1);
    chk("t6_pend_hold", 32'(ref_pending), 32'(ev_pend_before));
    chk("t6_pend3", 32'(ref_pending), 32'd3);
    sync_ref = 0; lat = -1;
    run(5);
    chk("t6_busy_ref", 32'(cmd_type), 32'd1);
    @(negedge clk);
    rst = 1;
    #1;
    chk("t6_rst_outs", 32'(outvec()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 0;
    init_r = 0; wr_want = 0; lat = 3;
    run(3);
    chk("t6_idle_type", 32'(cmd_type), 32'd0);

    // Random traffic
    do_reset();
    for (int r = 0; r < 30; r++) begin
      init_r     = ($urandom_range(0, 9) != 0);
      wr_persist = $urandom_range(0, 1) != 0;
      rd_persist = $urandom_range(0, 1) != 0;
      if (!wr_want) wr_want = $urandom_range(0, 1) != 0;
      if (!rd_want) rd_want = $urandom_range(0, 1) != 0;
      lat = $urandom_range(0, 6);
      run($urandom_range(20, 60));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
